// File: rtl/gcd_sched_pkg.sv
// Shared state encoding and constants for the GCD job scheduler.
// GCD_FIN_ADDR must track the finish address of the Stein program binary.
package gcd_sched_pkg;

    localparam int GCD_FIN_ADDR = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    // The shared counter has to hold the largest of the three phase lengths.
    function automatic int cnt_width(input int timeout, input int clr, input int drain);
        int w;
        w = $clog2(timeout + 1);
        if ($clog2(clr + 1) > w) w = $clog2(clr + 1);
        if ($clog2(drain + 1) > w) w = $clog2(drain + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/gcd_sched_cnt.sv
// Loadable phase counter: counts down to zero, or up to a saturating limit.
// last flags the final cycle of the current phase in either direction.
module gcd_sched_cnt #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            if (up) begin
                if (count_reg < limit) count_reg <= count_reg + 1'b1;
            end else if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Up mode flags the cycle whose increment would reach the limit.
    assign last = up ? (count_reg >= (limit - W'(1))) : (count_reg == '0);

endmodule

// File: rtl/gcd_job_sched.sv
// Job front-end for the GCD core: accepts an operand pair, resets/loads/runs
// the core to its finish address under a watchdog, and returns the result.
module gcd_job_sched
    import gcd_sched_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 8,
    parameter int FIN_ADDR     = GCD_FIN_ADDR,
    parameter int CLR_CYCLES   = 1,
    parameter int DRAIN_CYCLES = 10,
    parameter int TIMEOUT      = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_g,
    output logic              rsp_err,
    output logic              busy,
    output logic              core_rst,
    output logic              core_en,
    output logic              core_ld,
    output logic [WIDTH-1:0]  core_a,
    output logic [WIDTH-1:0]  core_b,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [WIDTH-1:0]  core_res
);

    localparam int              CW         = cnt_width(TIMEOUT, CLR_CYCLES, DRAIN_CYCLES);
    localparam logic [CW-1:0]   CLR_LOAD   = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0]   DRAIN_LOAD = CW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [CW-1:0]   WD_LIMIT   = CW'(TIMEOUT);
    localparam logic [ADDR_W-1:0] FIN      = ADDR_W'(FIN_ADDR);

    sched_state_t     state_reg, state_next;
    logic             req_fire, rsp_fire, fin_seen;
    logic             cnt_load, cnt_en, cnt_up, cnt_last;
    logic [CW-1:0]    cnt_load_val;
    logic [WIDTH-1:0] core_a_next, core_b_next, rsp_g_next;
    logic             rsp_err_next;

    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign fin_seen = (core_addr == FIN);
    assign cnt_up   = (state_reg == ST_RUN);

    gcd_sched_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .limit    (WD_LIMIT),
        .last     (cnt_last)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        core_a_next  = core_a;
        core_b_next  = core_b;
        rsp_g_next   = rsp_g;
        rsp_err_next = rsp_err;
        unique case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_a == '0 || req_b == '0) begin
                        state_next   = ST_DONE;
                        rsp_g_next   = req_a | req_b;
                        rsp_err_next = 1'b0;
                    end else begin
                        state_next   = ST_CLR;
                        core_a_next  = req_a;
                        core_b_next  = req_b;
                        cnt_load     = 1'b1;
                        cnt_load_val = CLR_LOAD;
                    end
                end
            end
            ST_CLR: begin
                cnt_en = 1'b1;
                if (cnt_last) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next   = ST_RUN;
                cnt_load     = 1'b1;
                cnt_load_val = '0;
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                // Finish wins over a watchdog expiry on the same cycle.
                if (fin_seen) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_next   = ST_DONE;
                        rsp_g_next   = core_res;
                        rsp_err_next = 1'b0;
                    end else begin
                        state_next   = ST_DRAIN;
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_LOAD;
                    end
                end else if (cnt_last) begin
                    state_next   = ST_DONE;
                    rsp_g_next   = '0;
                    rsp_err_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_next   = ST_DONE;
                    rsp_g_next   = core_res;
                    rsp_err_next = 1'b0;
                end
            end
            ST_DONE: begin
                if (rsp_fire) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Every output is a register decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_g     <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            core_ld   <= 1'b0;
            core_a    <= '0;
            core_b    <= '0;
        end else begin
            state_reg <= state_next;
            req_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_DONE);
            rsp_g     <= rsp_g_next;
            rsp_err   <= rsp_err_next;
            busy      <= (state_next != ST_IDLE);
            core_rst  <= (state_next == ST_IDLE) || (state_next == ST_CLR) || (state_next == ST_DONE);
            core_en   <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            core_ld   <= (state_next == ST_LOAD);
            core_a    <= core_a_next;
            core_b    <= core_b_next;
        end
    end

endmodule

// File: tb/tb_gcd_job_sched.sv
// Self-checking bench for gcd_job_sched with a small Euclid core model and a
// response scoreboard; one line is printed per retired job.
module tb_gcd_job_sched;
    import gcd_sched_pkg::*;

    localparam int WIDTH   = 32;
    localparam int ADDR_W  = 8;
    localparam int FIN     = GCD_FIN_ADDR;
    localparam int CLR_C   = 2;
    localparam int DRAIN_C = 3;
    localparam int TMO     = 64;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic             err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic              core_rst, core_en, core_ld;
    logic [WIDTH-1:0]  req_a, req_b, rsp_g, core_a, core_b, core_res;
    logic [ADDR_W-1:0] core_addr;

    always #5 clk = ~clk;

    gcd_job_sched #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .FIN_ADDR(FIN),
        .CLR_CYCLES(CLR_C), .DRAIN_CYCLES(DRAIN_C), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_g(rsp_g), .rsp_err(rsp_err),
        .busy(busy), .core_rst(core_rst), .core_en(core_en), .core_ld(core_ld),
        .core_a(core_a), .core_b(core_b), .core_addr(core_addr), .core_res(core_res)
    );

    // Core stand-in: one Euclid step per enabled cycle, FIN_ADDR once b is zero.
    logic [WIDTH-1:0]  m_a = '0, m_b = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              stuck = 1'b0;
    assign core_res  = m_a;
    assign core_addr = m_addr;

    always @(posedge clk) begin
        if (core_rst) begin
            m_a <= '0; m_b <= '0; m_addr <= '0;
        end else if (core_ld) begin
            m_a <= core_a; m_b <= core_b; m_addr <= 8'd1;
        end else if (core_en) begin
            if (stuck) m_addr <= 8'd3;
            else if (m_b == '0) m_addr <= ADDR_W'(FIN);
            else begin
                m_a    <= m_b;
                m_b    <= m_a % m_b;
                m_addr <= (m_addr >= 8'd8) ? 8'd1 : m_addr + 8'd1;
            end
        end
    end

    int n_cmp = 0, n_bad = 0, n_acc = 0, n_rsp = 0;
    bit mon_on = 0, in_flight = 0;
    logic [WIDTH-1:0] cur_g = '0;
    logic             cur_err = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor and scoreboard.
    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("req_ready", req_ready, !in_flight);
            check_eq("busy", busy, in_flight);
            if (req_valid && req_ready) begin
                sb.push_back('{cur_g, cur_err});
                in_flight = 1;
                n_acc++;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", rsp_valid, 0);
                end else if (rsp_ready) begin
                    mon_e = sb.pop_front();
                    check_eq("rsp_g", rsp_g, mon_e.g);
                    check_eq("rsp_err", rsp_err, mon_e.err);
                    in_flight = 0;
                    n_rsp++;
                    $display("job %0d: g=%0h err=%0b (expected g=%0h err=%0b)",
                             n_rsp, rsp_g, rsp_err, mon_e.g, mon_e.err);
                end else begin
                    check_eq("stall_g", rsp_g, sb[0].g);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] g, input logic e);
        int acc0;
        bit got;
        acc0 = n_acc;
        got  = 0;
        cur_g = g; cur_err = e; req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (n_acc != acc0) begin got = 1; break; end
        end
        req_valid = 1'b0;
        check_eq("accept", got, 1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 600; i++) begin
            if (n_rsp >= target) break;
            tick();
        end
        check_eq("rsp_wait", n_rsp >= target, 1);
    endtask

    // Called right after an accept; n counts cycles after the fire cycle.
    task automatic measure(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output int n, output int r, output int ld_cnt);
        bit fin, seen;
        n = 0; r = 0; ld_cnt = 0; fin = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (core_ld) begin
                ld_cnt++;
                check_eq("core_a", core_a, a);
                check_eq("core_b", core_b, b);
            end
            if (core_en && !fin) begin
                r++;
                if (core_addr == ADDR_W'(FIN)) fin = 1;
            end
            if (rsp_valid) begin seen = 1; break; end
        end
        check_eq("rsp_seen", seen, 1);
    endtask

    logic [WIDTH-1:0] vec_a[15], vec_b[15], vec_g[15];
    int n, r, ld_cnt, base, acc0, k, en_cnt;
    bit started, seen;

    initial begin
        vec_a = '{32'd48, 32'd35, 32'd0, 32'h8000_0000, 32'd0, 32'd100, 32'd17, 32'd1071,
                  32'd81, 32'd13, 32'h100, 32'd270, 32'd144, 32'd55, 32'hFFFF_FFFF};
        vec_b = '{32'd18, 32'd21, 32'd7, 32'd0, 32'd0, 32'd75, 32'd5, 32'd462,
                  32'd27, 32'd13, 32'h10, 32'd192, 32'd96, 32'd34, 32'h0000_FFFF};
        vec_g = '{32'd6, 32'd7, 32'd7, 32'h8000_0000, 32'd0, 32'd25, 32'd1, 32'd21,
                  32'd27, 32'd13, 32'h10, 32'd6, 32'd48, 32'd1, 32'h0000_FFFF};
        req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_rsp_g", rsp_g, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_core_rst", core_rst, 1);
        check_eq("rst_core_en", core_en, 0);
        check_eq("rst_core_ld", core_ld, 0);
        check_eq("rst_core_a", core_a, 0);
        check_eq("rst_core_b", core_b, 0);
        rst = 1'b0;
        tick();
        check_eq("rst_release_ready", req_ready, 1);
        mon_on = 1;

        // Core path with latency against the formula, fire cycle and first valid cycle inclusive.
        send(32'd48, 32'd18, 32'd6, 1'b0);
        measure(32'd48, 32'd18, n, r, ld_cnt);
        check_eq("ld_once_48_18", ld_cnt, 1);
        check_eq("latency_48_18", n + 1, 1 + CLR_C + 1 + r + DRAIN_C + 1);
        tick();

        // Zero fast paths.
        send(32'd0, 32'd7, 32'd7, 1'b0);
        measure(32'd0, 32'd7, n, r, ld_cnt);
        check_eq("fast_latency", n, 1);
        check_eq("fast_no_ld", ld_cnt, 0);
        tick();
        send(32'd0, 32'd0, 32'd0, 1'b0);
        measure(32'd0, 32'd0, n, r, ld_cnt);
        check_eq("fast00_latency", n, 1);
        tick();

        // Back to back, stalling the response of every third job.
        base = n_rsp;
        for (int i = 0; i < 15; i++) begin
            send(vec_a[i], vec_b[i], vec_g[i], 1'b0);
            if (i % 3 == 2) begin
                rsp_ready = 1'b0;
                seen = 0;
                for (int j = 0; j < 300; j++) begin
                    if (rsp_valid) begin seen = 1; break; end
                    tick();
                end
                check_eq("stall_valid", seen, 1);
                repeat (5) tick();
                rsp_ready = 1'b1;
            end
        end
        wait_rsp(base + 15);

        // Watchdog: core never reaches FIN_ADDR.
        stuck = 1'b1;
        send(32'd50, 32'd20, 32'd0, 1'b1);
        k = 0; en_cnt = 0; started = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (core_ld) started = 1;
            else if (started) k++;
            if (core_en) en_cnt++;
            if (rsp_valid) begin seen = 1; break; end
        end
        check_eq("tmo_seen", seen, 1);
        check_eq("tmo_run_cycles", en_cnt, TMO);
        check_eq("tmo_valid_after_load", k, TMO + 1);
        tick();
        stuck = 1'b0;
        base = n_rsp;
        send(32'd100, 32'd75, 32'd25, 1'b0);
        wait_rsp(base + 1);

        // Asynchronous reset in the middle of RUN.
        send(32'd1071, 32'd462, 32'd21, 1'b0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (core_en) begin seen = 1; break; end
            tick();
        end
        check_eq("run_reached", seen, 1);
        #1;
        mon_on = 0;
        rst = 1'b1;
        #1;
        check_eq("arst_core_rst", core_rst, 1);
        check_eq("arst_core_en", core_en, 0);
        check_eq("arst_rsp_valid", rsp_valid, 0);
        check_eq("arst_busy", busy, 0);
        sb.delete();
        in_flight = 0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("arst_ready_low", req_ready, 0);
        tick();
        check_eq("arst_resume_ready", req_ready, 1);
        mon_on = 1;
        base = n_rsp;
        send(32'd35, 32'd21, 32'd7, 1'b0);
        wait_rsp(base + 1);

        // req_valid held high across two jobs.
        acc0 = n_acc;
        base = n_rsp;
        cur_g = 32'd48; cur_err = 1'b0; req_a = 32'd144; req_b = 32'd96; req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (n_rsp >= base + 2) break;
            tick();
        end
        req_valid = 1'b0;
        check_eq("hold_rsps", n_rsp - base, 2);
        check_eq("hold_accepts", n_acc - acc0, 2);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_job_sched.md
# gcd_job_sched

Hardware job front-end for the GCD core (Stein program on the pseudo-CPU). It sits between a requester and the core's control pins and does in RTL what the bench task does by hand: accept an operand pair, reset the core, load `a`/`b`, run the core until its controller address reaches the finish address, and return the result through a response handshake. Only one job is in flight at a time. A hang watchdog bounds every job.

## Interface
- `WIDTH`, 32: operand and result width.
- `ADDR_W`, 8: width of the core controller address.
- `FIN_ADDR`, 9: controller address that marks program completion.
- `CLR_CYCLES`, 1: minimum number of cycles `core_rst` stays high before each load (≥1).
- `DRAIN_CYCLES`, 10: cycles the core keeps running after `FIN_ADDR` is seen, before the result is sampled (≥0).
- `TIMEOUT`, 4096: maximum RUN cycles before the job is aborted (≥1).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_a`, `req_b` in WIDTH: operands.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_g` out WIDTH: GCD result.
- `rsp_err` out 1: the job hit the watchdog, and `rsp_g` is invalid.
- `busy` out 1: a job has been accepted and not yet retired.
- `core_rst` out 1: core reset.
- `core_en` out 1: core run enable.
- `core_ld` out 1: one-cycle load strobe for the core `a`/`b` registers.
- `core_a`, `core_b` out WIDTH: load values.
- `core_addr` in ADDR_W: core controller address.
- `core_res` in WIDTH: core `a` register (the result).

## Operation
- All outputs are registered.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_g`=0, `busy`=0, `core_rst`=1, `core_en`=0, `core_ld`=0, `core_a`=`core_b`=0.
- A request fires when `req_valid & req_ready`. A response fires when `rsp_valid & rsp_ready`.
- FSM states are IDLE, CLR, LOAD, RUN, DRAIN, DONE.
  - **IDLE**: `req_ready`=1 and `core_rst`=1.
    - On a request fire, latch the operands.
    - If `req_a`==0 or `req_b`==0, go to DONE with `rsp_g` = `req_a | req_b` and `rsp_err`=0. This fast path never touches the core. 0,0 returns 0.
    - Otherwise go to CLR.
  - **CLR**: `core_rst`=1 for `CLR_CYCLES` cycles, then go to LOAD.
  - **LOAD**: `core_rst`=0. `core_ld`=1 for exactly one cycle with the latched operands on `core_a`/`core_b`. Then go to RUN.
  - **RUN**: `core_en`=1 and the watchdog counts RUN cycles.
    - If `core_addr`==`FIN_ADDR`, go to DRAIN (this takes priority on the same cycle as the watchdog limit).
    - Else, when the count reaches `TIMEOUT`, go to DONE with `rsp_err`=1 and `rsp_g`=0.
  - **DRAIN**: `core_en` stays 1 for `DRAIN_CYCLES` cycles. On the last one, capture `core_res` into `rsp_g` and go to DONE. With `DRAIN_CYCLES`=0, capture on the cycle `FIN_ADDR` is seen.
  - **DONE**: `core_en`=0, `core_rst`=1, and `rsp_valid`=1. `rsp_g` and `rsp_err` are held stable until the response fires, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `req_ready`=0 outside IDLE. The same request must not be accepted twice.
- Operands are never modified in the block. Zero detection is a full WIDTH-bit compare.
- The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates. It clears on entry to RUN.

## Timing
- Core path latency, from request fire to `rsp_valid`: 1 + `CLR_CYCLES` + 1 + R + `DRAIN_CYCLES` + 1 cycles, where R is the number of RUN cycles up to and including the `FIN_ADDR` cycle.
- Fast-path latency: 1 cycle from request fire to `rsp_valid`.
- `rsp_valid` is held while `rsp_ready`=0, for any duration.
- Back to back: with `rsp_ready` tied high, the DONE→IDLE cycle is followed by `req_ready` one cycle later. There is no idle bubble beyond that.
- Asserting `rst` in any state (including mid-RUN) immediately forces the reset values. This aborts the job with no response.
- After `rst` deasserts, the block resumes in IDLE. `req_ready` rises on the first clock edge after deassertion.
- `core_addr` is sampled only in RUN and DRAIN. A stale `FIN_ADDR` during CLR or LOAD is ignored.

## Structure
- Package `gcd_sched_pkg` holds:
  - the state enum (IDLE/CLR/LOAD/RUN/DRAIN/DONE);
  - the default `FIN_ADDR` constant, shared with the program binary build.
- Sub-module `gcd_sched_cnt`: one loadable down/up counter with done flag. It is reused for the CLR length, the DRAIN length and the watchdog, since only one is active per state.

## Test plan
- (48, 18) → core loaded with 48/18 and `rsp_g`=6, `rsp_err`=0. Check latency matches the formula using the measured R.
- (0, 7) → `rsp_g`=7 one cycle after accept, with `core_ld` never asserted. (0, 0) → 0.
- 15 vectors back to back, with `rsp_ready` low for 5 cycles on every third job → every result is correct and `rsp_g` is stable while stalled.
- `TIMEOUT`=64 and `core_addr` stuck at 3 → `rsp_err`=1 and `rsp_g`=0 exactly 64 RUN cycles after LOAD. The next job runs normally.
- `rst` pulsed mid-RUN → `core_rst`=1, `core_en`=0 and `rsp_valid`=0 asynchronously. The next request (35, 21) → 7.
- `req_valid` held high while busy → exactly one accept per job, with `req_ready`=0 from accept until the response fires.
